// File: rtl/single_mips_pkg.sv
// Shared definitions for the single-cycle MIPS instruction-memory loader:
// loader FSM states and image stream framing constants.
package single_mips_pkg;

    // Bytes in the image length header, and bytes per instruction word.
    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/single_mips_byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream; full flags the byte
// that completes a word.
module single_mips_byte_packer
    import single_mips_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_out = word_q;
    assign full     = shift_en && !clear && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/single_mips_imem_loader.sv
// Streams a length-prefixed big-endian image into instruction memory and holds
// the core in reset until the whole image has been written.
module single_mips_imem_loader
    import single_mips_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_WORDS  = 256
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned LenW = 8 * HDR_BYTES;

    loader_state_e         state_q, state_d;
    logic [LenW-1:0]       n_q, n_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  core_rst_n_q, core_rst_n_d;

    logic                  xfer;
    logic [LenW-1:0]       n_hdr;
    logic [ADDR_WIDTH-1:0] wr_addr_live;
    logic                  pk_clear;
    logic                  pk_shift;
    logic [31:0]           pk_word;
    logic                  pk_full;

    single_mips_byte_packer u_packer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (pk_clear),
        .shift_en (pk_shift),
        .byte_in  (byte_data),
        .word_out (pk_word),
        .full     (pk_full)
    );

    assign byte_ready = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
    assign xfer       = byte_valid && byte_ready;
    // Header bytes arrive high first, so shifting left leaves N fully formed.
    assign n_hdr      = {n_q[LenW-9:0], byte_data};
    assign wr_addr_live = BASE_ADDR + ADDR_WIDTH'({word_cnt_q, 2'b00});

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        pk_clear   = 1'b0;
        pk_shift   = 1'b0;
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLenHi;
                    word_cnt_d = '0;
                    pk_clear   = 1'b1;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    n_d     = n_hdr;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    n_d = n_hdr;
                    if (n_hdr == '0) begin
                        state_d = StDone;
                    end else if (32'(n_hdr) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                pk_shift = xfer;
                if (pk_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                addr_d     = wr_addr_live;
                data_d     = DATA_WIDTH'(pk_word);
                word_cnt_d = word_cnt_q + 16'd1;
                state_d    = (word_cnt_d == n_q) ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase
        core_rst_n_d = (state_d == StDone);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            n_q          <= '0;
            word_cnt_q   <= '0;
            addr_q       <= BASE_ADDR;
            data_q       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Live values during the write strobe, last written values otherwise.
    assign imem_wr_en   = (state_q == StWrite);
    assign imem_wr_addr = imem_wr_en ? wr_addr_live : addr_q;
    assign imem_wr_data = imem_wr_en ? DATA_WIDTH'(pk_word) : data_q;

    assign core_rst_n = core_rst_n_q;
    assign busy       = byte_ready || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StError);

endmodule

// File: tb/tb_single_mips_imem_loader.sv
// Directed bench for the image loader: two instances (base 0x400 and base 0)
// share one byte stream; writes are captured and checked against fixed vectors.
module tb_single_mips_imem_loader;

    localparam logic [31:0] BaseA = 32'h0000_0400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;

    logic        a_ready, a_wr_en, a_core_rst_n, a_busy, a_done, a_error;
    logic [31:0] a_addr, a_data;
    logic        b_ready, b_wr_en, b_core_rst_n, b_busy, b_done, b_error;
    logic [31:0] b_addr, b_data;

    always #5 clk = ~clk;

    single_mips_imem_loader #(.BASE_ADDR(BaseA)) dut_a (
        .CLK(clk), .RST_N(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(a_ready), .imem_wr_en(a_wr_en),
        .imem_wr_addr(a_addr), .imem_wr_data(a_data), .core_rst_n(a_core_rst_n),
        .busy(a_busy), .done(a_done), .error(a_error)
    );

    single_mips_imem_loader dut_b (
        .CLK(clk), .RST_N(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(b_ready), .imem_wr_en(b_wr_en),
        .imem_wr_addr(b_addr), .imem_wr_data(b_data), .core_rst_n(b_core_rst_n),
        .busy(b_busy), .done(b_done), .error(b_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
    logic        prev_wr_en = 1'b0;

    // Write capture plus the always-on protocol checks.
    always @(negedge clk) begin
        if (a_wr_en) begin
            wa_addr.push_back(a_addr);
            wa_data.push_back(a_data);
            check_eq("wr_en_consecutive", 32'(prev_wr_en), 32'd0);
            check_eq("ready_during_write", 32'(a_ready), 32'd0);
        end
        if (b_wr_en) begin
            wb_addr.push_back(b_addr);
            wb_data.push_back(b_data);
        end
        prev_wr_en = a_wr_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns just after the edge that samples start.
    task automatic pulse_start();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns just after the edge on which the byte transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        tries = 0;
        while (!a_ready && tries < 16) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 16) check_eq("ready_timeout", 32'(a_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stalls);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(tmp[31:24], stalls ? int'($urandom_range(0, 3)) : 0);
            tmp = tmp << 8;
        end
    endtask

    initial begin
        logic [31:0] words[3];
        words[0] = 32'h1122_3344;
        words[1] = 32'hA5B6_C7D8;
        words[2] = 32'hDEAD_BEEF;

        // Reset values.
        tick(2);
        check_eq("rst_byte_ready", 32'(a_ready), 32'd0);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_done_error", {30'd0, a_done, a_error}, 32'd0);
        check_eq("rst_core_rst_n", 32'(a_core_rst_n), 32'd0);
        check_eq("rst_wr_en", 32'(a_wr_en), 32'd0);
        check_eq("rst_wr_addr", a_addr, BaseA);
        check_eq("rst_wr_data", a_data, 32'd0);

        // Idle ignores traffic until start.
        @(negedge clk);
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        tick(3);
        check_eq("idle_busy", 32'(a_busy), 32'd0);
        check_eq("idle_ready", 32'(a_ready), 32'd0);

        // Single word, no stalls.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h2008_0005, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        check_eq("one_wr_en", 32'(b_wr_en), 32'd1);
        check_eq("one_wr_addr_b", b_addr, 32'h0);
        check_eq("one_wr_data_b", b_data, 32'h2008_0005);
        check_eq("one_wr_addr_a", a_addr, BaseA);
        check_eq("one_done_early", 32'(a_done), 32'd0);
        @(negedge clk);
        check_eq("one_done", 32'(a_done), 32'd1);
        check_eq("one_core_rst_n", 32'(b_core_rst_n), 32'd1);
        check_eq("one_wr_en_off", 32'(b_wr_en), 32'd0);
        check_eq("one_busy", 32'(a_busy), 32'd0);
        check_eq("one_hold_addr", b_addr, 32'h0);
        check_eq("one_hold_data", b_data, 32'h2008_0005);
        tick(1);
        check_eq("one_write_count", 32'(wb_addr.size()), 32'd1);

        // Restart from DONE, three words with random gaps, start during DATA.
        wa_addr.delete();
        wa_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("restart_core_rst_n", 32'(a_core_rst_n), 32'd0);
        check_eq("restart_done", 32'(a_done), 32'd0);
        check_eq("restart_busy", 32'(a_busy), 32'd1);
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_byte(8'h03, int'($urandom_range(0, 3)));
        send_word(words[0], 1'b1);
        send_byte(words[1][31:24], 1);
        send_byte(words[1][23:16], 2);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_in_data_busy", 32'(a_busy), 32'd1);
        tick(3);
        send_byte(words[1][15:8], 0);
        send_byte(words[1][7:0], 2);
        send_word(words[2], 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
        tick(2);
        check_eq("multi_write_count", 32'(wa_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wa_addr.size()) begin
                check_eq($sformatf("multi_addr%0d", i), wa_addr[i], BaseA + 32'(4 * i));
                check_eq($sformatf("multi_data%0d", i), wa_data[i], words[i]);
            end
        end
        check_eq("multi_done", 32'(a_done), 32'd1);

        // Empty image, then oversize image.
        wa_addr.delete();
        wa_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check_eq("empty_done", 32'(a_done), 32'd1);
        check_eq("empty_core_rst_n", 32'(a_core_rst_n), 32'd1);
        tick(2);
        check_eq("empty_no_write", 32'(wa_addr.size()), 32'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check_eq("big_error", 32'(a_error), 32'd1);
        check_eq("big_core_rst_n", 32'(a_core_rst_n), 32'd0);
        check_eq("big_ready", 32'(a_ready), 32'd0);
        check_eq("big_busy_done", {30'd0, a_busy, a_done}, 32'd0);

        // N == MAX_WORDS accepted; reset mid-load, then reload.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2;
        check_eq("max_busy", 32'(a_busy), 32'd1);
        check_eq("max_error", 32'(a_error), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(a_ready), 32'd0);
        check_eq("midrst_flags", {29'd0, a_busy, a_done, a_error}, 32'd0);
        check_eq("midrst_core_rst_n", 32'(a_core_rst_n), 32'd0);
        check_eq("midrst_wr_en", 32'(a_wr_en), 32'd0);
        check_eq("midrst_addr", a_addr, BaseA);
        check_eq("midrst_data", a_data, 32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check_eq("post_rst_idle", 32'(a_busy), 32'd0);
        wa_addr.delete();
        wa_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        tick(2);
        check_eq("reload_count", 32'(wa_addr.size()), 32'd1);
        if (wa_addr.size() > 0) begin
            check_eq("reload_addr", wa_addr[0], BaseA);
            check_eq("reload_data", wa_data[0], 32'hCAFE_F00D);
        end
        check_eq("reload_done", 32'(a_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
